// File: rtl/icache_responder.sv
// ----------------------------------------------------------------------------
// icache_responder
//
// Direct-mapped instruction cache. It serves one fetch request at a time from
// the instruction fetcher. A hit answers on the next cycle. A miss refills the
// whole line with word reads from the memory controller and then answers.
//
// Build option:
//   ICACHE_CRITICAL_WORD_FIRST_EN
//     Undefined (default): the refill reads words 0..N-1. The response is
//       sent from the RESP state after the full line has been installed.
//     Defined: the refill starts at the requested word and wraps around.
//       The response pulse comes in the cycle after the first MC_done.
//       The line becomes valid only after the last word has arrived.
//
// Ports:
//   clk         clock; all state changes on the rising edge
//   rst         asynchronous active-low reset
//   rdy         global enable; when 0 all state and outputs hold
//   clr         flush; cancels any pending response
//   IC_pc_sgn   fetch request valid
//   IC_pc       fetch address (bits [1:0] ignored)
//   IC_ins_sgn  response valid, 1-cycle pulse
//   IC_ins      instruction word
//   MC_req      memory word-read request (level)
//   MC_addr     word-aligned memory read address
//   MC_done     memory read complete (1-cycle pulse)
//   MC_data     memory read data, valid with MC_done
// ----------------------------------------------------------------------------
module icache_responder #(
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clr,
    input  logic        IC_pc_sgn,
    input  logic [31:0] IC_pc,
    output logic        IC_ins_sgn,
    output logic [31:0] IC_ins,
    output logic        MC_req,
    output logic [31:0] MC_addr,
    input  logic        MC_done,
    input  logic [31:0] MC_data
);

    // state  | meaning
    // IDLE   | waiting for a fetch; hits are answered from here
    // REFILL | reading the missing line word by word from memory
    // RESP   | sending the response after a full-line refill

    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << OFFSET_W;
    localparam int TAG_W = 32 - INDEX_W - OFFSET_W - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state;
    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q    [LINES];
    logic [31:0]         data_q   [LINES][WORDS];
    logic [31:0]         line_buf [WORDS];

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [OFFSET_W-1:0] req_off;
    logic [OFFSET_W-1:0] word_q;     // word currently being read
    logic [OFFSET_W-1:0] cnt_q;      // number of words already received
    logic                cancel_q;   // clr was seen during this refill

    logic [OFFSET_W-1:0] pc_off;
    logic [INDEX_W-1:0]  pc_index;
    logic [TAG_W-1:0]    pc_tag;
    logic                hit;
    logic [OFFSET_W-1:0] start_word;
    logic [OFFSET_W-1:0] next_word;
    logic                refill_beat;
    logic                last_word;
    logic                unused_pc_lsb;

    assign pc_off        = IC_pc[OFFSET_W+1:2];
    assign pc_index      = IC_pc[INDEX_W+OFFSET_W+1:OFFSET_W+2];
    assign pc_tag        = IC_pc[31:INDEX_W+OFFSET_W+2];
    assign unused_pc_lsb = &{1'b0, IC_pc[1:0]};

    assign hit         = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
    assign next_word   = word_q + 1'b1;
    assign refill_beat = rdy && (state == REFILL) && MC_done;
    assign last_word   = (cnt_q == OFFSET_W'(WORDS - 1));

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    assign start_word = pc_off;
`else
    assign start_word = '0;
`endif

    // Line storage. Writes happen only in REFILL and lookups only in IDLE.
    // So the array always has a single user in any cycle. The tag and data
    // contents need no reset, because valid_q guards them.
    always_ff @(posedge clk) begin
        if (refill_beat) begin
            line_buf[word_q] <= MC_data;
            if (last_word) begin
                tag_q[req_index] <= req_tag;
                for (int w = 0; w < WORDS; w++) begin
                    data_q[req_index][OFFSET_W'(w)] <=
                        (OFFSET_W'(w) == word_q) ? MC_data : line_buf[OFFSET_W'(w)];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            valid_q    <= '0;
            IC_ins_sgn <= 1'b0;
            IC_ins     <= '0;
            MC_req     <= 1'b0;
            MC_addr    <= '0;
            req_tag    <= '0;
            req_index  <= '0;
            req_off    <= '0;
            word_q     <= '0;
            cnt_q      <= '0;
            cancel_q   <= 1'b0;
        end else if (rdy) begin
            IC_ins_sgn <= 1'b0;
            case (state)
                IDLE: begin
                    if (IC_pc_sgn && !clr) begin
                        req_tag   <= pc_tag;
                        req_index <= pc_index;
                        req_off   <= pc_off;
                        if (hit) begin
                            IC_ins_sgn <= 1'b1;
                            IC_ins     <= data_q[pc_index][pc_off];
                        end else begin
                            state    <= REFILL;
                            MC_req   <= 1'b1;
                            MC_addr  <= {pc_tag, pc_index, start_word, 2'b00};
                            word_q   <= start_word;
                            cnt_q    <= '0;
                            cancel_q <= 1'b0;
                        end
                    end
                end

                REFILL: begin
                    if (clr) begin
                        cancel_q <= 1'b1;
                    end
                    if (MC_done) begin
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
                        // The first word returned is the requested word.
                        if (cnt_q == '0 && !clr && !cancel_q) begin
                            IC_ins_sgn <= 1'b1;
                            IC_ins     <= MC_data;
                        end
`endif
                        if (last_word) begin
                            MC_req             <= 1'b0;
                            valid_q[req_index] <= 1'b1;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
                            state <= IDLE;
`else
                            state <= (clr || cancel_q) ? IDLE : RESP;
`endif
                        end else begin
                            word_q  <= next_word;
                            cnt_q   <= cnt_q + 1'b1;
                            MC_addr <= {req_tag, req_index, next_word, 2'b00};
                        end
                    end
                end

                RESP: begin
                    if (!clr) begin
                        IC_ins_sgn <= 1'b1;
                        IC_ins     <= line_buf[req_off];
                    end
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// ----------------------------------------------------------------------------
// tb_icache_responder
//
// Directed testbench for icache_responder. It uses a table of hit/drop
// vectors and hand-written sequences for refill, conflict, clr, rdy and
// reset. Memory word at address a reads back as 32'hC0DE_0000 | a[15:0].
// ----------------------------------------------------------------------------
module tb_icache_responder;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        clr = 1'b0;
    logic        IC_pc_sgn = 1'b0;
    logic [31:0] IC_pc = '0;
    logic        IC_ins_sgn;
    logic [31:0] IC_ins;
    logic        MC_req;
    logic [31:0] MC_addr;
    logic        MC_done = 1'b0;
    logic [31:0] MC_data = '0;

    int checks   = 0;
    int failures = 0;
    int pulse_cnt = 0;

    icache_responder #(.INDEX_W(6), .OFFSET_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .clr        (clr),
        .IC_pc_sgn  (IC_pc_sgn),
        .IC_pc      (IC_pc),
        .IC_ins_sgn (IC_ins_sgn),
        .IC_ins     (IC_ins),
        .MC_req     (MC_req),
        .MC_addr    (MC_addr),
        .MC_done    (MC_done),
        .MC_data    (MC_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (IC_ins_sgn) pulse_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Serve a full line refill starting at the negedge after the miss was accepted.
    task automatic do_refill(input logic [31:0] pc, input int clr_word, input int rdy_word);
        logic [31:0] base;
        logic [31:0] a;
        int start, w, p0, exp_delta;
        logic exp_default;
        base  = {pc[31:4], 4'h0};
        start = CWF ? int'(pc[3:2]) : 0;
        p0    = pulse_cnt;
        for (int k = 0; k < 4; k++) begin
            w = (start + k) % 4;
            a = base | 32'(w * 4);
            if (k == rdy_word) begin
                rdy = 1'b0;
                repeat (3) begin
                    step();
                    chk("rdy0_mc_req", 32'(MC_req), 32'd1);
                    chk("rdy0_mc_addr", MC_addr, a);
                end
                rdy = 1'b1;
            end
            chk("refill_mc_req", 32'(MC_req), 32'd1);
            chk("refill_mc_addr", MC_addr, a);
            step();
            chk("refill_addr_hold", MC_addr, a);
            MC_done = 1'b1;
            MC_data = mem(a);
            clr     = (k == clr_word);
            step();
            MC_done = 1'b0;
            MC_data = '0;
            clr     = 1'b0;
            if (CWF && k == 0) begin
                chk("cwf_first_pulse", 32'(IC_ins_sgn), 32'(clr_word != 0));
                if (clr_word != 0) chk("cwf_first_ins", IC_ins, mem(pc));
            end
        end
        chk("refill_req_drop", 32'(MC_req), 32'd0);
        chk("refill_no_early_pulse", 32'(IC_ins_sgn), 32'd0);
        exp_default = (clr_word < 0);
        step();
        chk("resp_pulse", 32'(IC_ins_sgn), CWF ? 32'd0 : 32'(exp_default));
        if (!CWF && exp_default) chk("resp_ins", IC_ins, mem(pc));
        step();
        chk("resp_single", 32'(IC_ins_sgn), 32'd0);
        exp_delta = (clr_word < 0 || (CWF && clr_word > 0)) ? 1 : 0;
        chk("pulse_count", 32'(pulse_cnt - p0), 32'(exp_delta));
    endtask

    task automatic miss_req(input logic [31:0] pc, input int clr_word, input int rdy_word);
        IC_pc_sgn = 1'b1;
        IC_pc     = pc;
        step();
        IC_pc_sgn = 1'b0;
        chk("miss_no_resp", 32'(IC_ins_sgn), 32'd0);
        do_refill(pc, clr_word, rdy_word);
    endtask

    typedef struct {
        logic        vld;
        logic [31:0] pc;
        logic        clr;
        logic        exp_sgn;
        logic [31:0] exp_ins;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0000, 1'b0, 1'b1, 32'hC0DE_0000};
        vecs[1] = '{1'b1, 32'h0000_0004, 1'b0, 1'b1, 32'hC0DE_0004};
        vecs[2] = '{1'b1, 32'h0000_000C, 1'b0, 1'b1, 32'hC0DE_000C};
        vecs[3] = '{1'b0, 32'h0000_0008, 1'b0, 1'b0, 32'h0000_0000};
        vecs[4] = '{1'b1, 32'h0000_0008, 1'b1, 1'b0, 32'h0000_0000};
        vecs[5] = '{1'b1, 32'h0000_0008, 1'b0, 1'b1, 32'hC0DE_0008};

        // Reset state
        repeat (2) step();
        chk("rst_ins_sgn", 32'(IC_ins_sgn), 32'd0);
        chk("rst_ins", IC_ins, 32'd0);
        chk("rst_mc_req", 32'(MC_req), 32'd0);
        chk("rst_mc_addr", MC_addr, 32'd0);
        rst = 1'b1;
        step();

        // First miss, line 0
        miss_req(32'h0000_0008, -1, -1);

        // Back-to-back hits plus idle and clr-dropped requests
        for (int i = 0; i <= 6; i++) begin
            if (i > 0) begin
                chk("tbl_sgn", 32'(IC_ins_sgn), 32'(vecs[i-1].exp_sgn));
                if (vecs[i-1].exp_sgn) chk("tbl_ins", IC_ins, vecs[i-1].exp_ins);
                chk("tbl_mc_req", 32'(MC_req), 32'd0);
            end
            if (i < 6) begin
                IC_pc_sgn = vecs[i].vld;
                IC_pc     = vecs[i].pc;
                clr       = vecs[i].clr;
            end else begin
                IC_pc_sgn = 1'b0;
                clr       = 1'b0;
            end
            step();
        end

        // Conflict: same index, different tag, then original misses again
        miss_req(32'h0000_0400, -1, -1);
        miss_req(32'h0000_0000, -1, -1);

        // clr during the 2nd word: line installed, no response
        miss_req(32'h0000_0020, 1, -1);
        IC_pc_sgn = 1'b1;
        IC_pc     = 32'h0000_0020;
        step();
        IC_pc_sgn = 1'b0;
        chk("clr_rehit_sgn", 32'(IC_ins_sgn), 32'd1);
        chk("clr_rehit_ins", IC_ins, 32'hC0DE_0020);
        chk("clr_rehit_mc_req", 32'(MC_req), 32'd0);
        step();

        // rdy=0 for 3 cycles before the 2nd word
        miss_req(32'h0000_0030, -1, 1);

        // Asynchronous reset mid-refill
        IC_pc_sgn = 1'b1;
        IC_pc     = 32'h0000_0050;
        step();
        IC_pc_sgn = 1'b0;
        chk("rstmid_mc_req", 32'(MC_req), 32'd1);
        MC_done = 1'b1;
        MC_data = mem(32'h0000_0050);
        step();
        MC_done = 1'b0;
        MC_data = '0;
        chk("rstmid_addr2", MC_addr, 32'h0000_0054);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_ins_sgn", 32'(IC_ins_sgn), 32'd0);
        chk("rstmid_ins", IC_ins, 32'd0);
        chk("rstmid_mc_req", 32'(MC_req), 32'd0);
        chk("rstmid_mc_addr", MC_addr, 32'd0);
        step();
        rst = 1'b1;
        step();
        miss_req(32'h0000_0000, -1, -1);
        miss_req(32'h0000_0050, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Direct-mapped instruction cache that serves fetch requests from the instruction fetcher.
- Responder on the fetch side:
  - request in: IC_pc_sgn / IC_pc
  - response out: IC_ins_sgn / IC_ins
- Initiator on the memory-controller side: word reads used to refill a missing line.
- One request in flight at a time. Hits return in 1 cycle; misses return after the line refill.

Parameters:
- INDEX_W, 6: line index bits (2^INDEX_W lines).
- OFFSET_W, 2: word-in-line bits (2^OFFSET_W 32-bit words per line).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; when 0, all state is frozen and outputs hold.
- clr  in  1  pipeline flush; cancels any pending response.
- IC_pc_sgn  in  1  fetch request valid.
- IC_pc  in  32  fetch address; bits [1:0] ignored.
- IC_ins_sgn  out  1  response valid, 1-cycle pulse.
- IC_ins  out  32  instruction word.
- MC_req  out  1  memory word-read request, level.
- MC_addr  out  32  word-aligned read address.
- MC_done  in  1  read complete, 1-cycle pulse.
- MC_data  in  32  read data, valid with MC_done.

Behaviour:
- Address split:
  - offset = pc[OFFSET_W+1:2]
  - index = pc[INDEX_W+OFFSET_W+1:OFFSET_W+2]
  - tag = pc[31:INDEX_W+OFFSET_W+2]
- Storage per line: valid bit, tag, 2^OFFSET_W data words.
- Reset (rst=0, any time, asynchronous):
  - all valid bits = 0
  - state = IDLE
  - IC_ins_sgn = 0, IC_ins = 0
  - MC_req = 0, MC_addr = 0
  - a refill in progress is abandoned.
- rdy=0: no state, array or output register changes.
- States and transitions:
  - IDLE:
    - Accepts a request when IC_pc_sgn=1 and clr=0; latches pc.
    - Hit: next cycle IC_ins_sgn=1, IC_ins=word; stays in IDLE. Back-to-back hits give 1 response per cycle.
    - Miss: goes to REFILL; IC_ins_sgn=0.
  - REFILL:
    - Reads words 0..2^OFFSET_W-1 of the line in order.
    - MC_addr = {tag, index, word, 2'b00}.
    - MC_req stays high until MC_done.
    - On MC_done, MC_data is written to the line buffer, and MC_addr advances next cycle with MC_req kept high.
    - After the last MC_done:
      - MC_req=0 next cycle
      - line written with valid=1 and new tag
      - go to RESP.
  - RESP:
    - One cycle with IC_ins_sgn=1, IC_ins = latched-offset word, unless cancelled by clr.
    - Then back to IDLE.
- Busy handling: IC_pc_sgn is ignored outside IDLE. The fetcher keeps at most one request outstanding.
- clr:
  - Forces IC_ins_sgn=0 the next cycle.
  - In IDLE, drops any request presented in the same cycle.
  - During REFILL, the refill still completes and the line is installed, but no response is sent; RESP is skipped and the block returns to IDLE.
  - clr in RESP suppresses the pulse.
- IC_ins_sgn is never high two cycles in a row for the same accepted request.
- Single-writer array: hit lookup and refill write never occur in the same cycle.

Optional Feature:
- Macro: ICACHE_CRITICAL_WORD_FIRST_EN.
- Defined:
  - Refill starts at the requested offset and wraps modulo 2^OFFSET_W.
  - The response pulse occurs in the cycle after the first MC_done, while the remaining words continue to fill.
  - The line valid bit is set only after the last word.
  - No new request is accepted until the line is installed and the block is back in IDLE.
- Undefined:
  - Refill order 0..N-1; response only after the full line (RESP state).

Test Plan:
- Reset, then IC_pc_sgn=1, IC_pc=0x0000_0008:
  - miss; MC_addr sequence 0x0, 0x4, 0x8, 0xC
  - after 4th MC_done, single IC_ins_sgn pulse with IC_ins = data returned for 0x8.
- After the line at 0x0 is filled, requests 0x0, 0x4, 0xC on consecutive cycles:
  - three consecutive 1-cycle-latency responses
  - MC_req stays 0.
- Conflict test: fill 0x0000_0000, then request 0x0000_0400 (same index, different tag, defaults):
  - miss and refill
  - a subsequent 0x0000_0000 request misses again.
- clr asserted during the 2nd word of a refill:
  - all 4 words are still fetched and no IC_ins_sgn pulse occurs
  - a re-request of the same pc hits with 1-cycle latency.
- rdy=0 for 3 cycles mid-refill, with MC_done held 0: MC_req and MC_addr stable; the refill resumes when rdy=1.
- rst=0 asserted between clock edges mid-refill:
  - outputs go to 0 immediately
  - the next request to that line misses.
- With ICACHE_CRITICAL_WORD_FIRST_EN defined, request 0x8:
  - MC_addr sequence 0x8, 0xC, 0x0, 0x4
  - IC_ins_sgn pulses the cycle after the first MC_done.
